// File: rtl/axi4_write_slave.sv
// axi4_write_slave: AXI4 write-path slave (INCR bursts only) that stores
// beats in an internal word-addressed memory and returns a B response.
// Ports:
//   clk, ARESET                - clock, synchronous active-high reset
//   AWADDR/AWLEN/AWSIZE        - burst start byte address, beats-1, log2 beat bytes
//   AWVALID/AWREADY            - address channel handshake
//   WDATA/WLAST/WVALID/WREADY  - write data channel
//   BRESP/BVALID/BREADY        - write response channel (00 OKAY, 10 SLVERR)
//   mem_raddr/mem_rdata        - debug read port, one-cycle registered latency
module axi4_write_slave #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned MEM_DEPTH  = 1024
) (
   input  logic                         clk,
   input  logic                         ARESET,
   input  logic [ADDR_WIDTH-1:0]        AWADDR,
   input  logic [7:0]                   AWLEN,
   input  logic [2:0]                   AWSIZE,
   input  logic                         AWVALID,
   output logic                         AWREADY,
   input  logic [DATA_WIDTH-1:0]        WDATA,
   input  logic                         WLAST,
   input  logic                         WVALID,
   output logic                         WREADY,
   output logic [1:0]                   BRESP,
   output logic                         BVALID,
   input  logic                         BREADY,
   input  logic [$clog2(MEM_DEPTH)-1:0] mem_raddr,
   output logic [DATA_WIDTH-1:0]        mem_rdata
);

   localparam int unsigned IDX_W    = $clog2(MEM_DEPTH);
   localparam int unsigned BYTES    = DATA_WIDTH / 8;
   localparam int unsigned SIZE_LOG = $clog2(BYTES);
   localparam int unsigned AW1      = ADDR_WIDTH + 1;
   localparam int unsigned PAGE_W   = 24;

   typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

   state_t                state_q, state_d;
   logic [AW1-1:0]        addr_q, addr_d;
   logic [7:0]            len_q, len_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [2:0]            size_q, size_d;
   logic                  aw_err_q, aw_err_d;
   logic                  wlast_err_q, wlast_err_d;
   logic                  awready_q, awready_d;
   logic                  wready_q, wready_d;
   logic                  bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic [DATA_WIDTH-1:0] rdata_q;

   logic                  beat_c;
   logic                  mem_we_c;
   logic [IDX_W-1:0]      mem_waddr_c;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   // Burst attribute checks on the incoming AW request
   logic [AW1-1:0]        start_word_c, last_word_c;
   logic [ADDR_WIDTH-1:0] align_mask_c;
   logic [PAGE_W-1:0]     page_end_c;
   logic                  size_err_c, align_err_c, range_err_c, page_err_c;

   always_comb begin
      start_word_c = AW1'(AWADDR >> SIZE_LOG);
      // Extra top bit catches start + len overflowing the address space
      last_word_c  = start_word_c + AW1'(AWLEN);
      align_mask_c = ADDR_WIDTH'((32'd1 << AWSIZE) - 32'd1);
      page_end_c   = PAGE_W'(AWADDR[11:0])
                   + (PAGE_W'({1'b0, AWLEN} + 9'd1) << AWSIZE);
      size_err_c   = (AWSIZE != 3'(SIZE_LOG));
      align_err_c  = ((AWADDR & align_mask_c) != '0);
      range_err_c  = (32'(last_word_c) >= MEM_DEPTH);
      page_err_c   = (page_end_c > PAGE_W'(4096));
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      size_d      = size_q;
      aw_err_d    = aw_err_q;
      wlast_err_d = wlast_err_q;
      mem_we_c    = 1'b0;
      beat_c      = WVALID & wready_q;
      mem_waddr_c = IDX_W'(addr_q >> SIZE_LOG);

      case (state_q)
         IDLE: begin
            if (AWVALID && awready_q) begin
               state_d     = DATA;
               addr_d      = AW1'(AWADDR);
               len_d       = AWLEN;
               size_d      = AWSIZE;
               cnt_d       = 8'd0;
               aw_err_d    = size_err_c | align_err_c | range_err_c | page_err_c;
               wlast_err_d = 1'b0;
            end
         end
         DATA: begin
            if (beat_c) begin
               // Attribute errors suppress writes; WLAST errors only affect BRESP
               mem_we_c = ~aw_err_q;
               addr_d   = addr_q + (AW1'(1) << size_q);
               cnt_d    = cnt_q + 8'd1;
               if (WLAST != (cnt_q == len_q)) begin
                  wlast_err_d = 1'b1;
               end
               if (cnt_q == len_q) begin
                  state_d = RESP;
               end
            end
         end
         RESP: begin
            if (bvalid_q && BREADY) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      awready_d = (state_d == IDLE);
      wready_d  = (state_d == DATA);
      bvalid_d  = (state_d == RESP);
      bresp_d   = ((state_d == RESP) && (aw_err_d || wlast_err_d)) ? 2'b10 : 2'b00;
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (ARESET) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         size_q      <= '0;
         aw_err_q    <= 1'b0;
         wlast_err_q <= 1'b0;
         awready_q   <= 1'b1;
         wready_q    <= 1'b0;
         bvalid_q    <= 1'b0;
         bresp_q     <= 2'b00;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         size_q      <= size_d;
         aw_err_q    <= aw_err_d;
         wlast_err_q <= wlast_err_d;
         awready_q   <= awready_d;
         wready_q    <= wready_d;
         bvalid_q    <= bvalid_d;
         bresp_q     <= bresp_d;
      end
   end

   // Storage array; contents survive reset
   always_ff @(posedge clk) begin
      if (mem_we_c && !ARESET) begin
         mem[mem_waddr_c] <= WDATA;
      end
   end

   // Debug read port; same-cycle write returns the old word
   always_ff @(posedge clk) begin
      if (ARESET) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= mem[mem_raddr];
      end
   end

   assign AWREADY   = awready_q;
   assign WREADY    = wready_q;
   assign BVALID    = bvalid_q;
   assign BRESP     = bresp_q;
   assign mem_rdata = rdata_q;

endmodule

// File: doc/axi4_write_slave.md
Name: axi4_write_slave

Overview:
- AXI4 memory-mapped slave write path: accepts AW bursts, consumes W beats, stores them in an internal word-addressed memory, returns B.
- Sits directly downstream of the write-channel driver on `axi_if`.
- Has an auxiliary registered read port so benches can check memory contents without the AR/R path.
- INCR bursts only; no WSTRB, IDs or user signals.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; must be 32 or 64.
- ADDR_WIDTH, 16, byte address width.
- MEM_DEPTH, 1024, memory depth in DATA_WIDTH words.

Ports:
- clk  in  1  clock; everything updates on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- AWADDR  in  ADDR_WIDTH  burst start byte address.
- AWLEN  in  8  beats minus 1.
- AWSIZE  in  3  log2(bytes per beat).
- AWVALID  in  1  address valid.
- AWREADY  out  1  address ready.
- WDATA  in  DATA_WIDTH  write data.
- WLAST  in  1  last beat marker.
- WVALID  in  1  data valid.
- WREADY  out  1  data ready.
- BRESP  out  2  00 = OKAY, 10 = SLVERR.
- BVALID  out  1  response valid.
- BREADY  in  1  response ready.
- mem_raddr  in  $clog2(MEM_DEPTH)  debug read word index.
- mem_rdata  out  DATA_WIDTH  mem[mem_raddr], one-cycle registered latency.

Behaviour:
- Reset (ARESET high at a clock edge):
  - state = IDLE, AWREADY = 1, WREADY = 0, BVALID = 0, BRESP = 00, mem_rdata = 0.
  - Memory contents are not cleared.
  - Reset mid-burst abandons the burst: no further writes, and no B response for it.
- FSM states: IDLE, DATA, RESP.
- IDLE:
  - AWREADY = 1.
  - On AWVALID & AWREADY: latch AWADDR, AWLEN and AWSIZE; beat_cnt = 0; compute err; go to DATA.
  - AWREADY drops to 0 the next cycle.
- DATA:
  - WREADY = 1, AWREADY = 0.
  - First WREADY occurs one cycle after the AW handshake.
  - A beat is accepted only when WVALID & WREADY; gaps with WVALID low are allowed and simply wait.
  - Per accepted beat, if err = 0: mem[addr >> log2(DATA_WIDTH/8)] <= WDATA.
  - Per accepted beat: addr += (1 << AWSIZE); beat_cnt += 1.
  - Burst ends on the beat where beat_cnt == latched AWLEN, regardless of WLAST. Go to RESP; WREADY = 0 the next cycle.
  - WLAST mismatch (WLAST = 1 before the final beat, or 0 on the final beat) sets err; data still follows the err rule.
- RESP:
  - BVALID = 1, BRESP = err ? 10 : 00.
  - Both are held stable until BREADY.
  - On BVALID & BREADY: go to IDLE; BVALID = 0 and AWREADY = 1 the next cycle.
- err is set at AW acceptance if any of the following holds. When err is set, no memory writes occur for the whole burst, but all AWLEN+1 beats are still consumed.
  - AWSIZE != log2(DATA_WIDTH/8) (narrow transfers unsupported).
  - AWADDR not aligned to the beat size.
  - start word index + AWLEN >= MEM_DEPTH.
  - Burst crosses a 4 KB boundary: (AWADDR[11:0] + ((AWLEN+1) << AWSIZE)) > 4096.
- Only one outstanding burst. AWVALID during DATA/RESP is ignored and holds until IDLE.
- Simultaneous WVALID in the same cycle as the AW handshake: no beat is accepted, because WREADY = 0 in IDLE.
- Address arithmetic is done in ADDR_WIDTH+1 bits so that overflow is detected as out of range.
- Minimum burst latency (AW handshake to BVALID) is AWLEN+2 cycles with WVALID continuously high.
- mem_rdata <= mem[mem_raddr] every cycle. A read of a word written in the same cycle returns the old value.

Test Plan:
- Single beat: AWADDR = 0x0010, AWLEN = 0, AWSIZE = 2, WDATA = 0xDEADBEEF, WLAST = 1 -> BRESP = 00; mem_raddr = 4 gives 0xDEADBEEF; BVALID two cycles after AW handshake.
- 4-beat INCR with WVALID dropped between beats: AWADDR = 0x0100, AWLEN = 3, data 0x11..0x44 -> words 64..67 = 0x11, 0x22, 0x33, 0x44; BRESP = 00; WREADY high only in DATA.
- Out of range: AWADDR = 0x0FFC (word 1023), AWLEN = 1 -> 2 beats accepted, BRESP = 10, word 1023 unchanged.
- Bad attributes:
  - AWSIZE = 1 -> BRESP = 10, no writes.
  - AWADDR = 0x0002 -> BRESP = 10.
  - 4 KB crossing (AWADDR = 0x0FF8, AWLEN = 3, MEM_DEPTH = 4096) -> BRESP = 10.
- WLAST early on beat 1 of AWLEN = 3 -> 4 beats still accepted, data written, BRESP = 10. BREADY held low 5 cycles -> BVALID and BRESP stable; AWVALID ignored until the B handshake.
- ARESET pulsed mid-burst after beat 1 of AWLEN = 3 -> next cycle AWREADY = 1, WREADY = 0, BVALID = 0; a new burst completes with BRESP = 00.
